// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: set-2 scan-code decoder that collapses E0/F0/E1 prefixes into
// single buffered key events and turns keyboard status bytes into pulse flags.
module ps2_kbd_decoder #(
    parameter int TIMEOUT_US      = 2000,
    parameter bit DROP_FAKE_SHIFT = 1'b1
) (
    input  logic       clk6x,
    input  logic       reset,
    input  logic       ck1us,
    input  logic [7:0] kbd_rdata_i,
    input  logic       kbd_rvalid_i,
    output logic       kbd_rdeq_o,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_break_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic       bat_o,
    output logic       ovf_o,
    output logic       seq_err_o
);
    typedef enum logic [2:0] {IDLE, ST_E0, ST_F0, ST_E0F0, PAUSE} state_t;

    localparam logic [11:0] TMO_LAST = 12'(TIMEOUT_US - 1);
    // Pause tail after E1, indexed by idx; the top entry is never reached.
    localparam logic [7:0][7:0] PAUSE_SEQ = {8'h00, 8'h77, 8'hF0, 8'h14, 8'hF0, 8'hE1, 8'h77, 8'h14};

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] tmr_q, tmr_d;
    logic [7:0]  code_q, code_d;
    logic        ext_q, ext_d, brk_q, brk_d, valid_q, valid_d;
    logic        bat_q, bat_d, ovf_q, ovf_d, err_q, err_d;
    logic        slot_free, deq, bad, is_stat, emit, fake, e_ext, e_brk;
    logic [7:0]  b;

    always_comb begin
        b         = kbd_rdata_i;
        slot_free = !valid_q || key_ready_i;
        deq       = kbd_rvalid_i && slot_free;
        is_stat   = b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE ||
                    b == 8'hFC || b == 8'h00 || b == 8'hFF;
        bad       = is_stat || b == 8'hE0 || b == 8'hE1 || b == 8'hF0;
        state_d   = state_q;
        idx_d     = idx_q;
        tmr_d     = tmr_q;
        emit      = 1'b0;
        e_ext     = 1'b0;
        e_brk     = 1'b0;
        bat_d     = 1'b0;
        ovf_d     = 1'b0;
        err_d     = 1'b0;
        if (deq || state_q == IDLE) begin
            tmr_d = '0;
        end else if (ck1us) begin
            tmr_d   = tmr_q == TMO_LAST ? 12'd0 : tmr_q + 12'd1;
            state_d = tmr_q == TMO_LAST ? IDLE : state_q;
            err_d   = tmr_q == TMO_LAST;
        end
        if (deq) begin
            case (state_q)
                IDLE: begin
                    if (b == 8'hE0) state_d = ST_E0;
                    else if (b == 8'hF0) state_d = ST_F0;
                    else if (b == 8'hE1) begin
                        state_d = PAUSE;
                        idx_d   = 3'd0;
                    end
                    else if (b == 8'hAA) bat_d = 1'b1;
                    else if (b == 8'h00 || b == 8'hFF) ovf_d = 1'b1;
                    else emit = !is_stat;
                end
                ST_E0: begin
                    state_d = b == 8'hF0 ? ST_E0F0 : IDLE;
                    err_d   = b != 8'hF0 && bad;
                    emit    = !bad;
                    e_ext   = 1'b1;
                end
                ST_F0, ST_E0F0: begin
                    state_d = IDLE;
                    err_d   = bad;
                    emit    = !bad;
                    e_ext   = state_q == ST_E0F0;
                    e_brk   = 1'b1;
                end
                PAUSE: begin
                    state_d = b == PAUSE_SEQ[idx_q] && idx_q != 3'd6 ? PAUSE : IDLE;
                    idx_d   = idx_q + 3'd1;
                    err_d   = b != PAUSE_SEQ[idx_q];
                    emit    = b == PAUSE_SEQ[idx_q] && idx_q == 3'd6;
                    e_ext   = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        fake    = DROP_FAKE_SHIFT && e_ext && (b == 8'h12 || b == 8'h59);
        code_d  = emit && !fake ? b : code_q;
        ext_d   = emit && !fake ? e_ext : ext_q;
        brk_d   = emit && !fake ? e_brk : brk_q;
        valid_d = emit && !fake ? 1'b1 : valid_q && !key_ready_i;
    end

    always_ff @(posedge clk6x) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            code_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            valid_q <= 1'b0;
            bat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            valid_q <= valid_d;
            bat_q   <= bat_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign kbd_rdeq_o  = deq;
    assign key_code_o  = code_q;
    assign key_ext_o   = ext_q;
    assign key_break_o = brk_q;
    assign key_valid_o = valid_q;
    assign bat_o       = bat_q;
    assign ovf_o       = ovf_q;
    assign seq_err_o   = err_q;
endmodule
